// File: rtl/tx_mtrp_word.sv
// Bipolar return-to-zero word transmitter: serialises an NBIT word LSB first as
// half-bit TXP/TXN pulses plus a DAC line code. Optional feature macro: PARITY_EN.
module tx_mtrp_word #(
  parameter int NP   = 100,
  parameter int NBIT = 32,
  parameter int NGAP = 4,
  parameter int NS0  = 2048,
  parameter int AMP  = 1000
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            ce,
  input  logic [NBIT-1:0] dat,
  input  logic            st,
  output logic            TXP,
  output logic            TXN,
  output logic [11:0]     DAC,
  output logic            busy,
  output logic            done
);

  localparam int HALF = NP / 2;
  localparam int TW   = (NP > 1) ? $clog2(NP) : 1;
  localparam int BW   = $clog2(NBIT);
  localparam int GW   = $clog2(NGAP * NP);

  localparam logic [11:0] DAC_NULL = 12'(NS0);
  localparam logic [11:0] DAC_POS  = 12'(NS0 + AMP);
  localparam logic [11:0] DAC_NEG  = 12'(NS0 - AMP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [NBIT-1:0] shift, shift_n;
  logic [TW-1:0]   tact,  tact_n;
  logic [BW-1:0]   nbit,  nbit_n;
  logic [GW-1:0]   gcnt,  gcnt_n;
  logic            txp_n, txn_n, busy_n, done_n;
  logic [11:0]     dac_n;
  logic [NBIT-1:0] load_word;

`ifdef PARITY_EN
  // Top bit carries odd parity so the transmitted word always has an odd number of 1s.
  assign load_word = {~^dat[NBIT-2:0], dat[NBIT-2:0]};
`else
  assign load_word = dat;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_n = state;
    shift_n = shift;
    tact_n  = tact;
    nbit_n  = nbit;
    gcnt_n  = gcnt;
    txp_n   = 1'b0;
    txn_n   = 1'b0;
    busy_n  = busy;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (st) begin
          state_n = SEND;
          shift_n = load_word;
          tact_n  = '0;
          nbit_n  = '0;
          busy_n  = 1'b1;
        end
      end
      SEND: begin
        if (tact < TW'(HALF)) begin
          txp_n = shift[0];
          txn_n = ~shift[0];
        end
        if (tact == TW'(NP - 1)) begin
          tact_n  = '0;
          shift_n = shift >> 1;
          if (nbit == BW'(NBIT - 1)) begin
            state_n = GAP;
            gcnt_n  = '0;
          end else begin
            nbit_n = nbit + 1'b1;
          end
        end else begin
          tact_n = tact + 1'b1;
        end
      end
      GAP: begin
        if (gcnt == GW'(NGAP * NP - 1)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          gcnt_n = gcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    dac_n = txp_n ? DAC_POS : (txn_n ? DAC_NEG : DAC_NULL);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state <= IDLE;
      shift <= '0;
      tact  <= '0;
      nbit  <= '0;
      gcnt  <= '0;
      TXP   <= 1'b0;
      TXN   <= 1'b0;
      DAC   <= DAC_NULL;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (ce) begin
      state <= state_n;
      shift <= shift_n;
      tact  <= tact_n;
      nbit  <= nbit_n;
      gcnt  <= gcnt_n;
      TXP   <= txp_n;
      TXN   <= txn_n;
      DAC   <= dac_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule
